regfile_dump: RTL

- Sequential reader for the 32x32 register file.
- On a start pulse it walks every register address in order, from 0 to NUM_REGS-1.
- For each address it drives one register-file read port (S_Addr/S path) and captures the asynchronous read data.
- It streams each {address, data} pair out over a valid/ready handshake. Used for debug dump to UART/display and for end-of-test register checks in the lab datapath.

---
 rtl/regfile_dump.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks every register address and streams {addr, data} over valid/ready.
// Optional REGDUMP_CHECKSUM_EN adds a running modulo-2^DATA_W sum of the streamed words.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum,
  output logic              checksum_valid
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              csum_valid_q, csum_valid_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q       <= csum_d;
      csum_valid_q <= csum_valid_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    busy        = 1'b1;
    done        = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
    csum_d       = csum_q;
    csum_valid_d = csum_valid_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          ptr_d   = '0;
          state_d = S_LOAD;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d       = '0;
          csum_valid_d = 1'b0;
`endif
        end
      end
      // ptr has been stable for the whole cycle, so the async read data is safe to capture here.
      S_LOAD: begin
        out_data_d  = rd_data;
        out_addr_d  = ptr_q;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d = csum_q + out_data_q;
`endif
          if (ptr_q == LAST_ADDR) begin
            state_d = S_DONE;
`ifdef REGDUMP_CHECKSUM_EN
            csum_valid_d = 1'b1;
`endif
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_addr   = ptr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
`ifdef REGDUMP_CHECKSUM_EN
  assign checksum       = csum_q;
  assign checksum_valid = csum_valid_q;
`endif

endmodule
